// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Decodes a PS/2 set-2 byte stream from the receiver FIFO into make/break
//   events and tracks the keys currently held down. It also provides the
//   derived modifier state and a BCD count of key presses.
//
// Ports
//   clk, clrn    : system clock, asynchronous active-low reset
//   ready, in    : FIFO has a byte / the byte itself
//   nextdata_n   : low for one cycle to pop the byte just consumed
//   ev_*         : registered event (valid is a one-cycle strobe, the rest hold)
//   held_count   : number of occupied entries in the held-key table
//   overflow     : a press was dropped because the table was full (sticky)
//   shift/ctrl/alt, caps_lock, if_conflict, if_capital : keyboard state
//   key_count    : BCD press counter, digit 0 in bits [3:0]
module ps2_key_tracker #(
    parameter int MAX_KEYS     = 4,
    parameter int CNT_DIGITS   = 2,
    parameter int COUNT_REPEAT = 0
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    ready,
    input  logic [7:0]              in,
    output logic                    nextdata_n,
    output logic                    ev_valid,
    output logic [7:0]              ev_code,
    output logic                    ev_ext,
    output logic                    ev_break,
    output logic                    ev_repeat,
    output logic [3:0]              held_count,
    output logic                    overflow,
    output logic                    shift,
    output logic                    ctrl,
    output logic                    alt,
    output logic                    caps_lock,
    output logic                    if_conflict,
    output logic                    if_capital,
    output logic [4*CNT_DIGITS-1:0] key_count
);

    typedef enum logic [2:0] {BASE, EXT, BRK, EXT_BRK, PAUSE} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              skip_q, skip_d;
    logic                    nextdataN_q, nextdataN_d;
    logic                    evValid_q, evValid_d;
    logic [7:0]              evCode_q, evCode_d;
    logic                    evExt_q, evExt_d;
    logic                    evBreak_q, evBreak_d;
    logic                    evRepeat_q, evRepeat_d;
    logic [MAX_KEYS-1:0]     valid_q, valid_d;
    logic [MAX_KEYS-1:0]     entExt_q, entExt_d;
    logic [7:0]              entCode_q [MAX_KEYS];
    logic [7:0]              entCode_d [MAX_KEYS];
    logic                    overflow_q, overflow_d;
    logic                    caps_q, caps_d;
    logic [4*CNT_DIGITS-1:0] count_q, count_d;

    logic                    accept;
    logic                    isReply;
    logic                    keyEvent, keyBreak, keyExt, pauseDone;
    logic [MAX_KEYS-1:0]     hitVec, freeVec;
    logic                    hit, full;

    // BCD increment with ripple carry; all-9s wraps to all-0s
    function automatic logic [4*CNT_DIGITS-1:0] bcdInc(input logic [4*CNT_DIGITS-1:0] v);
        logic                    carry;
        logic [4*CNT_DIGITS-1:0] r;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < CNT_DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // nextdata_n doubles as the "not busy" flag, so at most one byte per two cycles
    assign accept  = ready && nextdataN_q;
    assign isReply = (in == 8'hAA) || (in == 8'hFA) || (in == 8'hEE) || (in == 8'hFE);

    // Prefix decoder: turns the byte stream into single make/break/pause strobes
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        keyEvent  = 1'b0;
        keyBreak  = 1'b0;
        keyExt    = 1'b0;
        pauseDone = 1'b0;
        if (accept) begin
            case (state_q)
                BASE: begin
                    if (in == 8'hE0) begin
                        state_d = EXT;
                    end else if (in == 8'hF0) begin
                        state_d = BRK;
                    end else if (in == 8'hE1) begin
                        state_d = PAUSE;
                        skip_d  = 3'd7;
                    end else if (!isReply) begin
                        keyEvent = 1'b1;
                    end
                end
                EXT: begin
                    if (in == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (in != 8'hE0) begin
                        keyEvent = 1'b1;
                        keyExt   = 1'b1;
                        state_d  = BASE;
                    end
                end
                BRK: begin
                    if (in != 8'hE0 && in != 8'hF0) begin
                        keyEvent = 1'b1;
                        keyBreak = 1'b1;
                        state_d  = BASE;
                    end
                end
                EXT_BRK: begin
                    if (in != 8'hE0 && in != 8'hF0) begin
                        keyEvent = 1'b1;
                        keyBreak = 1'b1;
                        keyExt   = 1'b1;
                        state_d  = BASE;
                    end
                end
                PAUSE: begin
                    // The E1 that entered PAUSE loaded 7, so the 7th following byte ends it
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        pauseDone = 1'b1;
                        state_d   = BASE;
                    end
                end
                default: state_d = BASE;
            endcase
        end
    end

    // Table lookup: the table never holds duplicates, so at most one hit bit is set
    always_comb begin
        for (int i = 0; i < MAX_KEYS; i++) begin
            hitVec[i] = valid_q[i] && (entCode_q[i] == in) && (entExt_q[i] == keyExt);
        end
    end

    assign hit     = |hitVec;
    assign full    = &valid_q;
    // Isolates the lowest clear bit of valid_q
    assign freeVec = ~valid_q & (valid_q + MAX_KEYS'(1));

    always_comb begin
        nextdataN_d = !accept;
        evValid_d   = 1'b0;
        evCode_d    = evCode_q;
        evExt_d     = evExt_q;
        evBreak_d   = evBreak_q;
        evRepeat_d  = evRepeat_q;
        valid_d     = valid_q;
        entExt_d    = entExt_q;
        entCode_d   = entCode_q;
        overflow_d  = overflow_q;
        caps_d      = caps_q;
        count_d     = count_q;
        if (pauseDone) begin
            evValid_d  = 1'b1;
            evCode_d   = 8'hE1;
            evExt_d    = 1'b0;
            evBreak_d  = 1'b0;
            evRepeat_d = 1'b0;
        end else if (keyEvent) begin
            evValid_d  = 1'b1;
            evCode_d   = in;
            evExt_d    = keyExt;
            evBreak_d  = keyBreak;
            evRepeat_d = !keyBreak && hit;
            if (keyBreak) begin
                valid_d = valid_q & ~hitVec;
            end else if (hit) begin
                if (COUNT_REPEAT != 0) begin
                    count_d = bcdInc(count_q);
                end
            end else begin
                count_d = bcdInc(count_q);
                if (!keyExt && in == 8'h58) begin
                    caps_d = !caps_q;
                end
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    for (int i = 0; i < MAX_KEYS; i++) begin
                        if (freeVec[i]) begin
                            valid_d[i]   = 1'b1;
                            entExt_d[i]  = keyExt;
                            entCode_d[i] = in;
                        end
                    end
                end
            end
        end
        // overflow stays set until every held key has been released
        if (valid_d == '0) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= BASE;
            skip_q      <= 3'd0;
            nextdataN_q <= 1'b1;
            evValid_q   <= 1'b0;
            evCode_q    <= 8'h00;
            evExt_q     <= 1'b0;
            evBreak_q   <= 1'b0;
            evRepeat_q  <= 1'b0;
            valid_q     <= '0;
            entExt_q    <= '0;
            for (int i = 0; i < MAX_KEYS; i++) begin
                entCode_q[i] <= 8'h00;
            end
            overflow_q  <= 1'b0;
            caps_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            nextdataN_q <= nextdataN_d;
            evValid_q   <= evValid_d;
            evCode_q    <= evCode_d;
            evExt_q     <= evExt_d;
            evBreak_q   <= evBreak_d;
            evRepeat_q  <= evRepeat_d;
            valid_q     <= valid_d;
            entExt_q    <= entExt_d;
            entCode_q   <= entCode_d;
            overflow_q  <= overflow_d;
            caps_q      <= caps_d;
            count_q     <= count_d;
        end
    end

    // Held count and modifiers are read straight off the registered table
    always_comb begin
        held_count = 4'd0;
        shift      = 1'b0;
        ctrl       = 1'b0;
        alt        = 1'b0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (valid_q[i]) begin
                held_count = held_count + 4'd1;
                if (!entExt_q[i] && (entCode_q[i] == 8'h12 || entCode_q[i] == 8'h59)) begin
                    shift = 1'b1;
                end
                if (entCode_q[i] == 8'h14) begin
                    ctrl = 1'b1;
                end
                if (entCode_q[i] == 8'h11) begin
                    alt = 1'b1;
                end
            end
        end
    end

    assign nextdata_n  = nextdataN_q;
    assign ev_valid    = evValid_q;
    assign ev_code     = evCode_q;
    assign ev_ext      = evExt_q;
    assign ev_break    = evBreak_q;
    assign ev_repeat   = evRepeat_q;
    assign overflow    = overflow_q;
    assign caps_lock   = caps_q;
    assign key_count   = count_q;
    assign if_conflict = shift & ctrl;
    assign if_capital  = shift ^ caps_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
//   Self-checking bench for ps2_key_tracker (MAX_KEYS=4, CNT_DIGITS=2,
//   COUNT_REPEAT=0). Table-driven byte vectors plus hand-written sequences;
//   expected events are queued when a byte is driven and compared when the
//   DUT strobes ev_valid.
module tb_ps2_key_tracker;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         evExp;
        ev_t        ev;
        logic [3:0] held;
        logic [7:0] cnt;
        bit         sh;
        bit         ct;
        bit         al;
        bit         caps;
        bit         ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ready;
    logic [7:0] in;
    logic       nextdata_n;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_repeat;
    logic [3:0] held_count;
    logic       overflow;
    logic       shift;
    logic       ctrl;
    logic       alt;
    logic       caps_lock;
    logic       if_conflict;
    logic       if_capital;
    logic [7:0] key_count;

    int   assertCount = 0;
    int   failCount   = 0;
    ev_t  expQ[$];
    vec_t vecs[$];

    ps2_key_tracker #(
        .MAX_KEYS    (4),
        .CNT_DIGITS  (2),
        .COUNT_REPEAT(0)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .in         (in),
        .nextdata_n (nextdata_n),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_repeat  (ev_repeat),
        .held_count (held_count),
        .overflow   (overflow),
        .shift      (shift),
        .ctrl       (ctrl),
        .alt        (alt),
        .caps_lock  (caps_lock),
        .if_conflict(if_conflict),
        .if_capital (if_capital),
        .key_count  (key_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [7:0] d, input bit e, input logic [7:0] c,
                                   input bit x, input bit b, input bit r,
                                   input logic [3:0] h, input logic [7:0] k,
                                   input bit sh, input bit ct, input bit al,
                                   input bit cp, input bit ov);
        vec_t v;
        v.data  = d;
        v.evExp = e;
        v.ev    = '{code: c, ext: x, brk: b, rpt: r};
        v.held  = h;
        v.cnt   = k;
        v.sh    = sh;
        v.ct    = ct;
        v.al    = al;
        v.caps  = cp;
        v.ovf   = ov;
        return v;
    endfunction

    function automatic logic [7:0] toBcd(input int n);
        return 8'((((n / 10) % 10) * 16) + (n % 10));
    endfunction

    // Scoreboard side: every ev_valid strobe must match the oldest queued event
    always @(negedge clk) begin
        if (clrn === 1'b1 && ev_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected event: got code %0h, expected none", ev_code);
            end else begin
                ev_t e;
                e = expQ.pop_front();
                checkVal("ev_code", 32'(ev_code), 32'(e.code));
                checkVal("ev_ext", 32'(ev_ext), 32'(e.ext));
                checkVal("ev_break", 32'(ev_break), 32'(e.brk));
                checkVal("ev_repeat", 32'(ev_repeat), 32'(e.rpt));
            end
        end
    end

    task automatic checkOutput(input string tag, input vec_t v);
        checkVal({tag, " held_count"}, 32'(held_count), 32'(v.held));
        checkVal({tag, " key_count"}, 32'(key_count), 32'(v.cnt));
        checkVal({tag, " shift"}, 32'(shift), 32'(v.sh));
        checkVal({tag, " ctrl"}, 32'(ctrl), 32'(v.ct));
        checkVal({tag, " alt"}, 32'(alt), 32'(v.al));
        checkVal({tag, " caps_lock"}, 32'(caps_lock), 32'(v.caps));
        checkVal({tag, " overflow"}, 32'(overflow), 32'(v.ovf));
        checkVal({tag, " if_conflict"}, 32'(if_conflict), 32'(v.sh & v.ct));
        checkVal({tag, " if_capital"}, 32'(if_capital), 32'(v.sh ^ v.caps));
    endtask

    // Drives one byte, waits (bounded) for the pop, checks state, then checks the
    // one-cycle nextdata_n / ev_valid pulse while ready is still held high
    task automatic applyStimulus(input string tag, input vec_t v);
        int n;
        if (v.evExp) expQ.push_back(v.ev);
        @(negedge clk);
        ready = 1'b1;
        in    = v.data;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
        end while (nextdata_n !== 1'b0 && n < 8);
        checkVal({tag, " nextdata_n pop"}, 32'(nextdata_n), 32'(0));
        checkVal({tag, " ev_valid"}, 32'(ev_valid), 32'(v.evExp));
        checkOutput(tag, v);
        @(negedge clk);
        checkVal({tag, " nextdata_n release"}, 32'(nextdata_n), 32'(1));
        checkVal({tag, " ev_valid pulse"}, 32'(ev_valid), 32'(0));
        ready = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, " nextdata_n"}, 32'(nextdata_n), 32'(1));
        checkVal({tag, " ev_valid"}, 32'(ev_valid), 32'(0));
        checkVal({tag, " ev_code"}, 32'(ev_code), 32'(0));
        checkVal({tag, " ev_flags"}, 32'({ev_ext, ev_break, ev_repeat}), 32'(0));
        checkVal({tag, " held_count"}, 32'(held_count), 32'(0));
        checkVal({tag, " overflow"}, 32'(overflow), 32'(0));
        checkVal({tag, " caps_lock"}, 32'(caps_lock), 32'(0));
        checkVal({tag, " key_count"}, 32'(key_count), 32'(0));
        checkVal({tag, " modifiers"}, 32'({shift, ctrl, alt, if_conflict, if_capital}), 32'(0));
    endtask

    initial begin
        int expCnt;
        clrn  = 1'b0;
        ready = 1'b0;
        in    = 8'h00;

        // Reference table: byte, event?, code, ext, brk, rpt, held, count, sh, ct, al, caps, ovf
        vecs.push_back(mkVec(8'h1C, 1, 8'h1C, 0, 0, 0, 4'd1, 8'h01, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h1C, 1, 8'h1C, 0, 0, 1, 4'd1, 8'h01, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h01, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h1C, 1, 8'h1C, 0, 1, 0, 4'd0, 8'h01, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h12, 1, 8'h12, 0, 0, 0, 4'd1, 8'h02, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h14, 1, 8'h14, 0, 0, 0, 4'd2, 8'h03, 1, 1, 0, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd2, 8'h03, 1, 1, 0, 0, 0));
        vecs.push_back(mkVec(8'h12, 1, 8'h12, 0, 1, 0, 4'd1, 8'h03, 0, 1, 0, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h03, 0, 1, 0, 0, 0));
        vecs.push_back(mkVec(8'h14, 1, 8'h14, 0, 1, 0, 4'd0, 8'h03, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hE0, 0, 8'h00, 0, 0, 0, 4'd0, 8'h03, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h75, 1, 8'h75, 1, 0, 0, 4'd1, 8'h04, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hE0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h04, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h04, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h75, 1, 8'h75, 1, 1, 0, 4'd0, 8'h04, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h58, 1, 8'h58, 0, 0, 0, 4'd1, 8'h05, 0, 0, 0, 1, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h05, 0, 0, 0, 1, 0));
        vecs.push_back(mkVec(8'h58, 1, 8'h58, 0, 1, 0, 4'd0, 8'h05, 0, 0, 0, 1, 0));
        vecs.push_back(mkVec(8'h58, 1, 8'h58, 0, 0, 0, 4'd1, 8'h06, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h06, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h58, 1, 8'h58, 0, 1, 0, 4'd0, 8'h06, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hE0, 0, 8'h00, 0, 0, 0, 4'd0, 8'h06, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h11, 1, 8'h11, 1, 0, 0, 4'd1, 8'h07, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(8'hE0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h07, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h07, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(8'h11, 1, 8'h11, 1, 1, 0, 4'd0, 8'h07, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hE0, 0, 8'h00, 0, 0, 0, 4'd0, 8'h07, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h14, 1, 8'h14, 1, 0, 0, 4'd1, 8'h08, 0, 1, 0, 0, 0));
        vecs.push_back(mkVec(8'hE0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h08, 0, 1, 0, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h08, 0, 1, 0, 0, 0));
        vecs.push_back(mkVec(8'h14, 1, 8'h14, 1, 1, 0, 4'd0, 8'h08, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hAA, 0, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hFA, 0, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hEE, 0, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hFE, 0, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h1C, 1, 8'h1C, 0, 0, 0, 4'd1, 8'h09, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h32, 1, 8'h32, 0, 0, 0, 4'd2, 8'h10, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h21, 1, 8'h21, 0, 0, 0, 4'd3, 8'h11, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h23, 1, 8'h23, 0, 0, 0, 4'd4, 8'h12, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h24, 1, 8'h24, 0, 0, 0, 4'd4, 8'h13, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd4, 8'h13, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(8'h1C, 1, 8'h1C, 0, 1, 0, 4'd3, 8'h13, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd3, 8'h13, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(8'h32, 1, 8'h32, 0, 1, 0, 4'd2, 8'h13, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd2, 8'h13, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(8'h21, 1, 8'h21, 0, 1, 0, 4'd1, 8'h13, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h13, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(8'h23, 1, 8'h23, 0, 1, 0, 4'd0, 8'h13, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd0, 8'h13, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h24, 1, 8'h24, 0, 1, 0, 4'd0, 8'h13, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h59, 1, 8'h59, 0, 0, 0, 4'd1, 8'h14, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h14, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(8'h59, 1, 8'h59, 0, 1, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        checkReset("reset");
        clrn = 1'b1;
        @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("v%0d", i), vecs[i]);
        end

        $display("[TB] pause sequence");
        applyStimulus("pause0", mkVec(8'hE1, 0, 8'h00, 0, 0, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));
        applyStimulus("pause1", mkVec(8'h14, 0, 8'h00, 0, 0, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));
        applyStimulus("pause2", mkVec(8'h77, 0, 8'h00, 0, 0, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));
        applyStimulus("pause3", mkVec(8'hE1, 0, 8'h00, 0, 0, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));
        applyStimulus("pause4", mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));
        applyStimulus("pause5", mkVec(8'h14, 0, 8'h00, 0, 0, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));
        applyStimulus("pause6", mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));
        applyStimulus("pause7", mkVec(8'h77, 1, 8'hE1, 0, 0, 0, 4'd0, 8'h14, 0, 0, 0, 0, 0));
        applyStimulus("postpause", mkVec(8'h1C, 1, 8'h1C, 0, 0, 0, 4'd1, 8'h15, 0, 0, 0, 0, 0));
        applyStimulus("postpauseF0", mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, 8'h15, 0, 0, 0, 0, 0));
        applyStimulus("postpauseBrk", mkVec(8'h1C, 1, 8'h1C, 0, 1, 0, 4'd0, 8'h15, 0, 0, 0, 0, 0));

        $display("[TB] BCD preload and wrap");
        expCnt = 15;
        while (expCnt < 99) begin
            expCnt++;
            applyStimulus("cnt make", mkVec(8'h1C, 1, 8'h1C, 0, 0, 0, 4'd1, toBcd(expCnt), 0, 0, 0, 0, 0));
            applyStimulus("cnt F0", mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd1, toBcd(expCnt), 0, 0, 0, 0, 0));
            applyStimulus("cnt brk", mkVec(8'h1C, 1, 8'h1C, 0, 1, 0, 4'd0, toBcd(expCnt), 0, 0, 0, 0, 0));
        end
        applyStimulus("wrap", mkVec(8'h1C, 1, 8'h1C, 0, 0, 0, 4'd1, 8'h00, 0, 0, 0, 0, 0));
        applyStimulus("caps", mkVec(8'h58, 1, 8'h58, 0, 0, 0, 4'd2, 8'h01, 0, 0, 0, 1, 0));

        $display("[TB] reset mid E0 F0");
        applyStimulus("midE0", mkVec(8'hE0, 0, 8'h00, 0, 0, 0, 4'd2, 8'h01, 0, 0, 0, 1, 0));
        applyStimulus("midF0", mkVec(8'hF0, 0, 8'h00, 0, 0, 0, 4'd2, 8'h01, 0, 0, 0, 1, 0));
        @(negedge clk);
        clrn = 1'b0;
        #1;
        checkReset("midreset");
        @(negedge clk);
        clrn = 1'b1;
        applyStimulus("afterreset", mkVec(8'h1C, 1, 8'h1C, 0, 0, 0, 4'd1, 8'h01, 0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        checkVal("scoreboard drained", 32'(expQ.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised successor to the single-key scan-code analyser; sits between the PS/2 receiver FIFO (ready/in/nextdata_n) and display/character logic.
- Decodes full set-2 byte streams (E0 extended prefix, F0 break prefix, E1 pause sequence) into make/break events.
- Tracks up to MAX_KEYS simultaneously held keys, modifier and caps-lock state, and a BCD count of key presses.

Parameters:
- MAX_KEYS, 4, depth of the held-key table (1..8).
- CNT_DIGITS, 2, number of BCD digits in key_count (1..4).
- COUNT_REPEAT, 0, 1 = typematic repeats of a held key also increment key_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clrn  input  1  asynchronous active-low reset.
- ready  input  1  FIFO has a byte on in.
- in  input  8  current FIFO byte.
- nextdata_n  output  1  low for one cycle = pop the FIFO byte just consumed.
- ev_valid  output  1  one-cycle strobe: a key event is on ev_*.
- ev_code  output  8  scan code of the event (E1 for pause).
- ev_ext  output  1  event carried an E0 prefix.
- ev_break  output  1  1 = release, 0 = press.
- ev_repeat  output  1  press of a key already held (typematic).
- held_count  output  4  number of valid table entries (0..MAX_KEYS).
- overflow  output  1  a press was dropped because the table was full.
- shift  output  1  left (12) or right (59) shift held.
- ctrl  output  1  ctrl (14, with or without E0) held.
- alt  output  1  alt (11, with or without E0) held.
- caps_lock  output  1  caps-lock toggle state.
- if_conflict  output  1  shift & ctrl (combinational from registered state).
- if_capital  output  1  shift ^ caps_lock (combinational).
- key_count  output  4*CNT_DIGITS  BCD press counter, digit 0 in bits [3:0].

Behaviour:
- Reset (clrn=0, async): nextdata_n=1, ev_* = 0, table empty, held_count=0, overflow=0, caps_lock=0, key_count=0, decoder state BASE, pause skip counter 0. Reset mid-sequence discards any pending prefix.
- Accept rule: a byte is consumed at the rising edge where ready=1 and nextdata_n=1. On that edge nextdata_n is registered 0; it returns to 1 on the next edge. No byte is consumed while nextdata_n=0, so the maximum rate is one byte per 2 cycles.
- Decoder states: BASE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skipping).
  - BASE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter=7; any other byte -> make event, ext=0.
  - EXT: F0 -> EXT_BRK; E0 -> stay; other byte -> make event, ext=1, -> BASE.
  - BRK: other byte -> break event, ext=0, -> BASE. E0/F0 in BRK -> stay (prefix kept).
  - EXT_BRK: other byte -> break event, ext=1, -> BASE.
  - PAUSE: decrement the counter per consumed byte. At 0, emit ev_code=E1, ev_break=0, ev_repeat=0 and -> BASE. Pause is not counted and not tabled.
- Bytes AA, FA, EE, FE in BASE are consumed and discarded, with no event.
- Event outputs are registered on the same edge that consumes the final byte. ev_valid is high exactly one cycle; ev_* hold their values until the next event.
- Make, key (ext,code) already in table: ev_repeat=1; no table change; key_count increments only if COUNT_REPEAT=1.
- Make, key not held, table has a free slot: insert into the lowest free slot; held_count+1; key_count+1; ev_repeat=0.
- Make, key not held, table full: event still emitted and key_count+1; no insert; overflow=1. overflow is sticky until held_count reaches 0.
- Break, key held: clear its slot; held_count-1. Break, key not held: event emitted, no table change.
- Modifiers are derived from the table contents on the same edge as the table update. caps_lock toggles on a non-repeat make of 58 (ext=0) only.
- key_count: per-digit BCD increment with carry; wraps from all-9s to all-0s.

Test Plan:
- Reset, then feed 1C (ready held 1) -> nextdata_n low 1 cycle; ev_valid with code=1C, ext=0, break=0, repeat=0; held_count=1; key_count=0x01.
- Feed 1C, 1C, F0 1C -> second 1C gives repeat=1 and key_count stays 0x01 (COUNT_REPEAT=0). Break event then gives held_count=0.
- Feed 12, 14 -> shift=1, ctrl=1, if_conflict=1. Then F0 12 -> if_conflict=0 and ctrl stays 1.
- Feed E0 75, then E0 F0 75 -> make then break events, both with ext=1, code=75. Feed 58 twice with a break between -> caps_lock 1 then 0.
- MAX_KEYS=4: press 1C, 32, 21, 23, 24 -> fifth press sets overflow=1 with held_count=4. Release all four -> overflow=0.
- Preload key_count=0x99 via 99 distinct presses, then one more -> key_count=0x00. Send E1 14 77 E1 F0 14 F0 77 -> single ev_code=E1, count unchanged. Assert clrn mid E0 F0 -> all outputs at reset values.
